// File: rtl/imm_ext_arbiter_if.sv
// Handshake bundle between two immediate requesters, the shared extension
// datapath and the result consumer.
interface imm_ext_arbiter_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
);
    logic             req0_valid;
    logic [IN_W-1:0]  req0_data;
    logic             req0_zext;
    logic             req0_ready;

    logic             req1_valid;
    logic [IN_W-1:0]  req1_data;
    logic             req1_zext;
    logic             req1_ready;

    logic             res_valid;
    logic [OUT_W-1:0] res_data;
    logic             res_id;
    logic             res_ready;

    // Requester/consumer side.
    modport master (
        output req0_valid, req0_data, req0_zext,
        input  req0_ready,
        output req1_valid, req1_data, req1_zext,
        input  req1_ready,
        input  res_valid, res_data, res_id,
        output res_ready
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_data, req0_zext,
        output req0_ready,
        input  req1_valid, req1_data, req1_zext,
        output req1_ready,
        output res_valid, res_data, res_id,
        input  res_ready
    );
endinterface

// File: rtl/imm_ext_arbiter.sv
// Two-port round-robin arbiter in front of a shared 8->16 sign/zero extender,
// with a one-entry registered result stage and saturating grant counters.
module imm_ext_arbiter #(
    parameter int unsigned IN_W       = 8,
    parameter int unsigned OUT_W      = 16,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    imm_ext_arbiter_if.slave bus_io,
    output logic [CNT_W-1:0] cnt0_o,
    output logic [CNT_W-1:0] cnt1_o
);

    localparam int unsigned ExtW = OUT_W - IN_W;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e             state_q, state_d;
    logic               rr_q, rr_d;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               id_q, id_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic can_accept;
    logic gnt0, gnt1;

    function automatic logic [OUT_W-1:0] extend(logic [IN_W-1:0] d, logic zext);
        return {{ExtW{d[IN_W-1] & ~zext}}, d};
    endfunction

    assign can_accept = (state_q == StEmpty) | bus_io.res_ready;

    // Grants depend only on valids, pointer and output-stage room, never on ready.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_accept) begin
            if (FIXED_PRIO) begin
                gnt0 = bus_io.req0_valid;
                gnt1 = bus_io.req1_valid & ~bus_io.req0_valid;
            end else begin
                gnt0 = bus_io.req0_valid & (~bus_io.req1_valid | ~rr_q);
                gnt1 = bus_io.req1_valid & (~bus_io.req0_valid | rr_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        data_d  = data_q;
        id_d    = id_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        unique case (state_q)
            StEmpty: if (gnt0 | gnt1) state_d = StFull;
            StFull:  if (bus_io.res_ready & ~(gnt0 | gnt1)) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase

        if (gnt0) begin
            data_d = extend(bus_io.req0_data, bus_io.req0_zext);
            id_d   = 1'b0;
            if (!FIXED_PRIO) rr_d = 1'b1;
            if (cnt0_q != {CNT_W{1'b1}}) cnt0_d = cnt0_q + CNT_W'(1);
        end else if (gnt1) begin
            data_d = extend(bus_io.req1_data, bus_io.req1_zext);
            id_d   = 1'b1;
            if (!FIXED_PRIO) rr_d = 1'b0;
            if (cnt1_q != {CNT_W{1'b1}}) cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            rr_q    <= 1'b0;
            data_q  <= '0;
            id_q    <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus_io.req0_ready = gnt0;
    assign bus_io.req1_ready = gnt1;
    assign bus_io.res_valid  = (state_q == StFull);
    assign bus_io.res_data   = data_q;
    assign bus_io.res_id     = id_q;
    assign cnt0_o            = cnt0_q;
    assign cnt1_o            = cnt1_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Bench for imm_ext_arbiter: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model of two configs.
module tb_imm_ext_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_ext_arbiter_if #(.IN_W(8), .OUT_W(16)) ifa ();
    imm_ext_arbiter_if #(.IN_W(8), .OUT_W(16)) ifb ();
    logic [15:0] cnt0_a, cnt1_a;
    logic [3:0]  cnt0_b, cnt1_b;

    imm_ext_arbiter #(.IN_W(8), .OUT_W(16), .FIXED_PRIO(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus_io(ifa), .cnt0_o(cnt0_a), .cnt1_o(cnt1_a)
    );
    imm_ext_arbiter #(.IN_W(8), .OUT_W(16), .FIXED_PRIO(1'b1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .bus_io(ifb), .cnt0_o(cnt0_b), .cnt1_o(cnt1_b)
    );

    logic        o_r0 [2];
    logic        o_r1 [2];
    logic        o_rv [2];
    logic        o_id [2];
    logic [15:0] o_data [2];
    logic [15:0] o_c0 [2];
    logic [15:0] o_c1 [2];
    assign o_r0[0] = ifa.req0_ready;  assign o_r0[1] = ifb.req0_ready;
    assign o_r1[0] = ifa.req1_ready;  assign o_r1[1] = ifb.req1_ready;
    assign o_rv[0] = ifa.res_valid;   assign o_rv[1] = ifb.res_valid;
    assign o_id[0] = ifa.res_id;      assign o_id[1] = ifb.res_id;
    assign o_data[0] = ifa.res_data;  assign o_data[1] = ifb.res_data;
    assign o_c0[0] = cnt0_a;          assign o_c0[1] = {12'h000, cnt0_b};
    assign o_c1[0] = cnt1_a;          assign o_c1[1] = {12'h000, cnt1_b};

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive(input logic v0, input logic [7:0] d0, input logic z0,
                         input logic v1, input logic [7:0] d1, input logic z1,
                         input logic rr);
        ifa.req0_valid = v0; ifa.req0_data = d0; ifa.req0_zext = z0;
        ifa.req1_valid = v1; ifa.req1_data = d1; ifa.req1_zext = z1;
        ifa.res_ready  = rr;
        ifb.req0_valid = v0; ifb.req0_data = d0; ifb.req0_zext = z0;
        ifb.req1_valid = v1; ifb.req1_data = d1; ifb.req1_zext = z1;
        ifb.res_ready  = rr;
    endtask

    typedef struct {
        logic v0; logic [7:0] d0; logic z0;
        logic v1; logic [7:0] d1; logic z1;
        logic rr;
        logic er0; logic er1; logic erv;
        logic [15:0] edata; logic eid;
        logic [15:0] ec0; logic [15:0] ec1;
    } vec_t;

    vec_t tbl [15];

    // Behavioural model state, one slot per DUT (0: round-robin, 1: fixed/CNT_W=4).
    bit          m_valid [2];
    logic [15:0] m_data [2];
    int          m_id [2];
    int          m_ptr [2];
    int          m_c0 [2];
    int          m_c1 [2];
    bit          m_fixed [2] = '{1'b0, 1'b1};
    int          m_max [2] = '{65535, 15};

    function automatic logic [15:0] m_ext(input logic [7:0] d, input logic z);
        if (z) return {8'h00, d};
        return 16'($signed(d));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 1'b0; m_data[k] = 16'h0; m_id[k] = 0;
            m_ptr[k] = 0; m_c0[k] = 0; m_c1[k] = 0;
        end
    endtask

    initial begin
        int winner [2];
        logic v0, v1, z0, z1, rr;
        logic [7:0] d0, d1;

        tbl[0]  = '{1'b1, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b1, 16'hFF80, 1'b0, 16'd1, 16'd0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hF3, 1'b1, 1'b1,
                    1'b0, 1'b1, 1'b1, 16'h00F3, 1'b1, 16'd1, 16'd1};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1,
                    1'b0, 1'b1, 1'b1, 16'h007F, 1'b1, 16'd1, 16'd2};
        tbl[3]  = '{1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1,
                    1'b1, 1'b0, 1'b1, 16'h0011, 1'b0, 16'd2, 16'd2};
        tbl[4]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1,
                    1'b0, 1'b1, 1'b1, 16'h0044, 1'b1, 16'd2, 16'd3};
        tbl[5]  = '{1'b1, 8'h55, 1'b0, 1'b1, 8'h66, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b1, 16'h0055, 1'b0, 16'd3, 16'd3};
        tbl[6]  = '{1'b1, 8'h77, 1'b0, 1'b1, 8'h88, 1'b0, 1'b1,
                    1'b0, 1'b1, 1'b1, 16'hFF88, 1'b1, 16'd3, 16'd4};
        tbl[7]  = '{1'b1, 8'hC0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b1, 16'hFFC0, 1'b0, 16'd4, 16'd4};
        tbl[8]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b1, 16'hFFC0, 1'b0, 16'd4, 16'd4};
        tbl[9]  = '{1'b1, 8'h5A, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b1, 16'hFFC0, 1'b0, 16'd4, 16'd4};
        tbl[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 16'd5, 16'd4};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'd5, 16'd4};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1,
                    1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'd5, 16'd4};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 16'hFF80, 1'b1, 16'd5, 16'd5};
        tbl[14] = '{1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0,
                    1'b0, 1'b0, 1'b1, 16'hFF80, 1'b1, 16'd5, 16'd5};

        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        chk("reset res_valid", 32'(o_rv[0]), 32'd0);
        chk("reset res_data", 32'(o_data[0]), 32'd0);
        chk("reset res_id", 32'(o_id[0]), 32'd0);
        chk("reset cnt0", 32'(o_c0[0]), 32'd0);
        chk("reset cnt1", 32'(o_c1[0]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v0, tbl[i].d0, tbl[i].z0, tbl[i].v1, tbl[i].d1, tbl[i].z1, tbl[i].rr);
            #1;
            chk($sformatf("vec%0d req0_ready", i), 32'(o_r0[0]), 32'(tbl[i].er0));
            chk($sformatf("vec%0d req1_ready", i), 32'(o_r1[0]), 32'(tbl[i].er1));
            @(posedge clk); #1;
            chk($sformatf("vec%0d res_valid", i), 32'(o_rv[0]), 32'(tbl[i].erv));
            if (tbl[i].erv) begin
                chk($sformatf("vec%0d res_data", i), 32'(o_data[0]), 32'(tbl[i].edata));
                chk($sformatf("vec%0d res_id", i), 32'(o_id[0]), 32'(tbl[i].eid));
            end
            chk($sformatf("vec%0d cnt0", i), 32'(o_c0[0]), 32'(tbl[i].ec0));
            chk($sformatf("vec%0d cnt1", i), 32'(o_c1[0]), 32'(tbl[i].ec1));
        end

        // Asynchronous reset while FULL, sampled before any further clock edge.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst res_valid", 32'(o_rv[0]), 32'd0);
        chk("async rst res_data", 32'(o_data[0]), 32'd0);
        chk("async rst cnt0", 32'(o_c0[0]), 32'd0);
        chk("async rst cnt1", 32'(o_c1[0]), 32'd0);
        chk("async rst fixed cnt0", 32'(o_c0[1]), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fixed priority: port 0 wins every contended cycle.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h40, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
            #1;
            chk("fixed req0_ready", 32'(o_r0[1]), 32'd1);
            chk("fixed req1_ready", 32'(o_r1[1]), 32'd0);
            @(posedge clk); #1;
            chk("fixed res_id", 32'(o_id[1]), 32'd0);
            chk("fixed res_data", 32'(o_data[1]), 32'h0040);
            chk("fixed cnt0", 32'(o_c0[1]), 32'(i + 1));
        end
        // Saturation of the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            @(posedge clk); #1;
            chk("sat cnt0", 32'(o_c0[1]), 32'((5 + i > 15) ? 15 : 5 + i));
        end
        chk("sat cnt1", 32'(o_c1[1]), 32'd0);

        // Randomized run of both configurations against the model.
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            v0 = ($urandom_range(0, 9) < 6);
            v1 = ($urandom_range(0, 9) < 6);
            d0 = 8'($urandom); d1 = 8'($urandom);
            z0 = 1'($urandom); z1 = 1'($urandom);
            rr = ($urandom_range(0, 9) < 7);
            drive(v0, d0, z0, v1, d1, z1, rr);
            #1;
            for (int k = 0; k < 2; k++) begin
                winner[k] = -1;
                if (!m_valid[k] || rr) begin
                    if (v0 && v1) winner[k] = m_fixed[k] ? 0 : m_ptr[k];
                    else if (v0) winner[k] = 0;
                    else if (v1) winner[k] = 1;
                end
                chk($sformatf("rnd%0d req0_ready", k), 32'(o_r0[k]), 32'(winner[k] == 0));
                chk($sformatf("rnd%0d req1_ready", k), 32'(o_r1[k]), 32'(winner[k] == 1));
            end
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                if (winner[k] == 0) begin
                    m_valid[k] = 1'b1; m_data[k] = m_ext(d0, z0); m_id[k] = 0;
                    if (m_c0[k] < m_max[k]) m_c0[k]++;
                    m_ptr[k] = 1;
                end else if (winner[k] == 1) begin
                    m_valid[k] = 1'b1; m_data[k] = m_ext(d1, z1); m_id[k] = 1;
                    if (m_c1[k] < m_max[k]) m_c1[k]++;
                    m_ptr[k] = 0;
                end else if (rr) begin
                    m_valid[k] = 1'b0;
                end
                chk($sformatf("rnd%0d res_valid", k), 32'(o_rv[k]), 32'(m_valid[k]));
                if (m_valid[k]) begin
                    chk($sformatf("rnd%0d res_data", k), 32'(o_data[k]), 32'(m_data[k]));
                    chk($sformatf("rnd%0d res_id", k), 32'(o_id[k]), 32'(m_id[k]));
                end
                chk($sformatf("rnd%0d cnt0", k), 32'(o_c0[k]), 32'(m_c0[k]));
                chk($sformatf("rnd%0d cnt1", k), 32'(o_c1[k]), 32'(m_c1[k]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
